// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row debounce,
// and a valid/ready key hand-off with overflow signalling.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  state_t state, state_n;

  logic [3:0]    sync_q;
  logic [3:0]    rows_s;
  logic [DW-1:0] div_q;
  logic          tick;
  logic [1:0]    col, col_n;
  logic [1:0]    cand_row, cand_row_n;
  logic [1:0]    cand_col, cand_col_n;
  logic [3:0]    cnt, cnt_n, cnt_inc;
  logic [1:0]    low_row;
  logic          any_low;
  logic          accept;
  logic [3:0]    acc_code;
  logic          load;
  logic          drop;
  logic [3:0]    key_code_n;
  logic          key_valid_n;

  // Reset is expected to be released synchronously to CLOCK_50.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      sync_q <= row_in;
      rows_s <= sync_q;
    end
  end

  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Lowest-index low row wins when several rows are pulled down.
  always_comb begin
    low_row = 2'd0;
    if (!rows_s[0]) begin
      low_row = 2'd0;
    end else if (!rows_s[1]) begin
      low_row = 2'd1;
    end else if (!rows_s[2]) begin
      low_row = 2'd2;
    end else if (!rows_s[3]) begin
      low_row = 2'd3;
    end
  end

  assign any_low = ~&rows_s;
  assign cnt_inc = cnt + 4'd1;
  assign col_out = ~(4'b0001 << col);

  always_comb begin
    state_n    = state;
    col_n      = col;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    cnt_n      = cnt;
    accept     = 1'b0;
    acc_code   = {cand_row, cand_col};
    unique case (state)
      SCAN: begin
        if (tick) begin
          if (!any_low) begin
            col_n = col + 2'd1;
          end else begin
            cand_row_n = low_row;
            cand_col_n = col;
            cnt_n      = 4'd1;
            if (DB_MAX == 4'd1) begin
              accept   = 1'b1;
              acc_code = {low_row, col};
              state_n  = PRESSED;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (any_low && (low_row == cand_row)) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              accept  = 1'b1;
              state_n = PRESSED;
            end
          end else begin
            state_n = SCAN;
            col_n   = col + 2'd1;
          end
        end
      end
      PRESSED: begin
        if (tick && rows_s[cand_row]) begin
          cnt_n = 4'd1;
          if (DB_MAX == 4'd1) begin
            state_n = SCAN;
            col_n   = col + 2'd1;
          end else begin
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (tick) begin
          if (rows_s[cand_row]) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_n = SCAN;
              col_n   = col + 2'd1;
            end
          end else begin
            state_n = PRESSED;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  // A freshly accepted key may replace one being consumed this cycle.
  assign load = accept && (!key_valid || key_ready);
  assign drop = accept && key_valid && !key_ready;

  always_comb begin
    key_code_n  = key_code;
    key_valid_n = key_valid;
    if (load) begin
      key_code_n  = acc_code;
      key_valid_n = 1'b1;
    end else if (key_valid && key_ready) begin
      key_valid_n = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SCAN;
      col       <= 2'd0;
      cand_row  <= 2'd0;
      cand_col  <= 2'd0;
      cnt       <= 4'd0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      cand_row  <= cand_row_n;
      cand_col  <= cand_col_n;
      cnt       <= cnt_n;
      key_code  <= key_code_n;
      key_valid <= key_valid_n;
      overflow  <= drop;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix keypad model plus
// a queue of expected key codes popped as keys are delivered.
module tb_keypad_scanner;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_ready = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overflow;

  logic [15:0] pressed = '0;
  logic [3:0]  row_force_n = 4'hF;
  logic [3:0]  rows_m;
  logic [1:0]  tcnt;
  logic        kv_prev = 1'b0;
  int          kv_rises = 0;
  int          ov_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  sb[$];

  always #5 CLOCK_50 = ~CLOCK_50;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .overflow (overflow)
  );

  always_comb begin
    rows_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) rows_m[r] = 1'b0;
  end

  assign row_in = rows_m & row_force_n;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) tcnt <= 2'd0;
    else tcnt <= tcnt + 2'd1;
  end

  always @(negedge CLOCK_50) begin
    if (key_valid && !kv_prev) kv_rises++;
    kv_prev = key_valid;
    if (overflow) ov_cnt++;
  end

  task automatic wait_tick();
    @(negedge CLOCK_50);
    while (tcnt != 2'd3) @(negedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_valid(input int lim, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge CLOCK_50);
      if (key_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (col_out !== 4'b1110) begin
      errors++;
      $display("FAIL rst_col got %b want 1110", col_out);
    end
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", key_valid);
    end
    checks++;
    if (key_code !== 4'h0) begin
      errors++;
      $display("FAIL rst_code got %h want 0", key_code);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf got %b want 0", overflow);
    end
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge CLOCK_50);
      #1;
      checks++;
      if (col_out !== 4'b1110) begin
        errors++;
        $display("FAIL first_tick_early clk%0d got %b want 1110", i, col_out);
      end
    end
    @(posedge CLOCK_50);
    #1;
    checks++;
    if (col_out !== 4'b1101) begin
      errors++;
      $display("FAIL first_tick got %b want 1101", col_out);
    end
  endtask

  task automatic test_idle();
    logic [3:0] want;
    int k0;
    k0 = kv_rises;
    want = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      want = {want[2:0], want[3]};
      checks++;
      if (col_out !== want) begin
        errors++;
        $display("FAIL idle_col step%0d got %b want %b", i, col_out, want);
      end
    end
    checks++;
    if (kv_rises != k0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got %0d keys want 0", kv_rises - k0);
    end
  endtask

  task automatic test_press();
    bit seen;
    logic [3:0] want;
    logic [3:0] c0;
    int k0;
    key_ready = 1'b1;
    k0 = kv_rises;
    sb.push_back(4'h9);
    pressed[9] = 1'b1;
    wait_valid(200, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL press_timeout got no key want 9");
    end else begin
      want = sb.pop_front();
      checks++;
      if (key_code !== want) begin
        errors++;
        $display("FAIL press_code got %h want %h", key_code, want);
      end
      @(negedge CLOCK_50);
      checks++;
      if (key_valid !== 1'b0) begin
        errors++;
        $display("FAIL press_1cyc got %b want 0", key_valid);
      end
    end
    repeat (10) wait_tick();
    checks++;
    if (kv_rises != k0 + 1) begin
      errors++;
      $display("FAIL press_repeat got %0d keys want 1", kv_rises - k0);
    end
    pressed[9] = 1'b0;
    repeat (6) wait_tick();
    checks++;
    if (kv_rises != k0 + 1) begin
      errors++;
      $display("FAIL press_release got %0d keys want 1", kv_rises - k0);
    end
    c0 = col_out;
    wait_tick();
    checks++;
    if (col_out !== {c0[2:0], c0[3]}) begin
      errors++;
      $display("FAIL press_rescan got %b want %b", col_out, {c0[2:0], c0[3]});
    end
  endtask

  task automatic test_bounce();
    logic [3:0] c0;
    int k0;
    k0 = kv_rises;
    wait_tick();
    c0 = col_out;
    row_force_n = 4'b1110;
    wait_tick();
    checks++;
    if (col_out !== c0) begin
      errors++;
      $display("FAIL bounce_hold1 got %b want %b", col_out, c0);
    end
    wait_tick();
    checks++;
    if (col_out !== c0) begin
      errors++;
      $display("FAIL bounce_hold2 got %b want %b", col_out, c0);
    end
    row_force_n = 4'hF;
    wait_tick();
    checks++;
    if (col_out !== {c0[2:0], c0[3]}) begin
      errors++;
      $display("FAIL bounce_next got %b want %b", col_out, {c0[2:0], c0[3]});
    end
    wait_tick();
    checks++;
    if (col_out !== {c0[1:0], c0[3:2]}) begin
      errors++;
      $display("FAIL bounce_scan got %b want %b", col_out, {c0[1:0], c0[3:2]});
    end
    repeat (4) @(negedge CLOCK_50);
    checks++;
    if (kv_rises != k0) begin
      errors++;
      $display("FAIL bounce_key got %0d keys want 0", kv_rises - k0);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    logic [3:0] held;
    int ov0;
    key_ready = 1'b0;
    ov0 = ov_cnt;
    held = 4'hx;
    sb.push_back(4'h5);
    pressed[5] = 1'b1;
    wait_valid(200, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ovf_first_timeout got no key want 5");
    end else begin
      held = sb.pop_front();
      checks++;
      if (key_code !== held) begin
        errors++;
        $display("FAIL ovf_first_code got %h want %h", key_code, held);
      end
    end
    pressed[5] = 1'b0;
    repeat (8) wait_tick();
    pressed[15] = 1'b1;
    for (int i = 0; i < 200 && ov_cnt == ov0; i++) @(negedge CLOCK_50);
    repeat (10) @(negedge CLOCK_50);
    checks++;
    if (ov_cnt != ov0 + 1) begin
      errors++;
      $display("FAIL ovf_pulse got %0d cycles want 1", ov_cnt - ov0);
    end
    checks++;
    if (key_code !== held) begin
      errors++;
      $display("FAIL ovf_keep got %h want %h", key_code, held);
    end
    pressed[15] = 1'b0;
    repeat (8) wait_tick();
    @(negedge CLOCK_50);
    checks++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold_valid got %b want 1", key_valid);
    end
    key_ready = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_consume got %b want 0", key_valid);
    end
  endtask

  task automatic test_multi_row();
    bit seen;
    logic [3:0] want;
    key_ready = 1'b1;
    sb.push_back(4'h4);
    pressed[4] = 1'b1;
    pressed[12] = 1'b1;
    wait_valid(200, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL multi_timeout got no key want 4");
    end else begin
      want = sb.pop_front();
      checks++;
      if (key_code !== want) begin
        errors++;
        $display("FAIL multi_code got %h want %h", key_code, want);
      end
    end
    pressed[4] = 1'b0;
    pressed[12] = 1'b0;
    repeat (8) wait_tick();
  endtask

  task automatic test_reset_debounce();
    logic [3:0] want;
    int idx;
    key_ready = 1'b1;
    wait_tick();
    row_force_n = 4'b1011;
    wait_tick();
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdb_async got col %b valid %b want 1110 0", col_out, key_valid);
    end
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    sb.push_back(4'h8);
    reset_n = 1'b1;
    idx = 0;
    for (int i = 1; i <= 40 && idx == 0; i++) begin
      @(negedge CLOCK_50);
      if (key_valid) idx = i;
    end
    checks++;
    if (idx != 12) begin
      errors++;
      $display("FAIL rdb_latency got %0d clks want 12", idx);
    end
    want = sb.pop_front();
    checks++;
    if (key_code !== want) begin
      errors++;
      $display("FAIL rdb_code got %h want %h", key_code, want);
    end
    row_force_n = 4'hF;
    repeat (8) wait_tick();
    checks++;
    if (sb.size() != 0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdb_end got %0d pending valid %b want 0 0", sb.size(), key_valid);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_press();
    test_bounce();
    test_overflow();
    test_multi_row();
    test_reset_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
